regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single synchronous write port (we/wa/wd) among NREQ writeback sources: ALU pipeline, load unit and multiply/divide unit. Arbitration is round-robin with a valid/ready handshake. The winning write is registered and presented to the register file one cycle after acceptance. Writes to x0 complete the handshake but never assert we. It sits between the execute/memory writeback sources and the register file write port.

Parameters:
NREQ, 3, number of write requesters (2..8)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  requester i has a write pending
req_addr  in  NREQ*AW  destination register of requester i, slice [i*AW +: AW]
req_data  in  NREQ*DW  write data of requester i, slice [i*DW +: DW]
req_ready  out  NREQ  one-hot or zero; grant/accept to requester i this cycle
we  out  1  register file write enable (registered)
wa  out  AW  register file write address (registered)
wd  out  DW  register file write data (registered)
claim_valid  in  1  issue stage reserves a destination register (scoreboard)
claim_addr  in  AW  register being reserved
busy  out  32  per-register pending-write bits (scoreboard)
claim_err  out  1  one-cycle pulse: previous claim targeted an already-busy register

Behaviour:
- Reset (rst_n=0 at clk edge): we=0, wa=0, wd=0, rr_ptr=0, busy=0, claim_err=0. req_ready=0 while rst_n=0.
- Arbitration, combinational:
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ; the first valid index wins.
  - req_ready[winner]=1; all other bits 0. No valid requester -> req_ready=0.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both 1.
  - A requester holds valid, addr and data stable until accepted.
  - req_ready does not depend on the same requester's data.
- Pointer update: on a transfer, rr_ptr <= winner+1, wrapping NREQ-1 -> 0. No transfer -> rr_ptr holds.
- Output stage, latency 1:
  - Cycle after a transfer: wa=addr, wd=data, we=(addr!=0).
  - Cycle after no transfer: we=0; wa and wd hold their last values.
  - The output stage never stalls; one write per cycle maximum.
- x0 write: accepted and consumed, we stays 0, rr_ptr advances normally.
- Simultaneous requests: exactly one granted per cycle. Any requester waits at most NREQ-1 cycles while continuously valid.
- Reset asserted mid-operation: a pending output write is dropped (we=0 next cycle). Requesters must re-present their writes.

Optional Feature:
RF_WB_SCOREBOARD_EN
- Defined:
  - claim_valid with claim_addr!=0 and busy[claim_addr]=0 sets busy[claim_addr] next cycle.
  - A committed write (we=1) clears busy[wa] at the following edge.
  - Claim and clear on the same address in the same cycle: the set wins.
  - Claim to a busy register is ignored and claim_err pulses 1 the next cycle.
  - busy[0] is always 0.
- Undefined: busy=0, claim_err=0, claim inputs ignored; no scoreboard flops are synthesized.

Decomposition:
- Shared package holds:
  - RF_NREGS=32, RF_AW=5, RF_DW=32.
  - REG_ZERO=5'd0.
  - Requester index constants WB_ALU=0, WB_LOAD=1, WB_MULDIV=2.
- One natural sub-module, rr_arbiter: parameterised NREQ round-robin grant logic (req, ptr -> one-hot grant, winner index).
- Output register and scoreboard stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, we=0, busy=0; first grant after release goes to index 0.
- Single write: req 1 valid, addr=5, data=0xDEADBEEF -> req_ready=3'b010 same cycle; next cycle we=1, wa=5, wd=0xDEADBEEF; following cycle we=0.
- Contention: all three valid continuously for 6 cycles, each with distinct addresses 1/2/3 -> grants in order 0,1,2,0,1,2; each held request waits ≤2 cycles.
- x0 write: req 0 addr=0, data=0x1234 -> req_ready[0]=1, we stays 0, next grant goes to index 1 if valid.
- Scoreboard (macro defined): claim addr=7 -> busy[7]=1; claim 7 again -> claim_err pulses once, busy unchanged; writeback to 7 accepted -> busy[7]=0 the cycle after we=1; claim and commit to 9 in the same cycle -> busy[9] stays 1.
- Reset mid-write: accept write to addr 4, assert rst_n=0 in the next cycle -> we=0 and busy=0 after that edge, rr_ptr=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared register-file constants and writeback requester indices
package regfile_wb_arbiter_pkg;

   localparam int RF_NREGS = 32;
   localparam int RF_AW    = 5;
   localparam int RF_DW    = 32;

   localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

   localparam int WB_ALU    = 0;
   localparam int WB_LOAD   = 1;
   localparam int WB_MULDIV = 2;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - combinational round-robin grant starting at ptr_i
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IW-1:0]   winner_o,
   output logic            any_o
);

   int idx;

   // Priority rotates so that index ptr_i is examined first, then ptr_i+1, wrapping.
   always_comb begin
      grant_o  = '0;
      winner_o = '0;
      any_o    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!any_o && req_i[idx]) begin
            any_o         = 1'b1;
            grant_o[idx]  = 1'b1;
            winner_o      = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register file write port
// RF_WB_SCOREBOARD_EN adds the per-register pending-write scoreboard (busy/claim_err).
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 we,
   output logic [AW-1:0]        wa,
   output logic [DW-1:0]        wd,
   input  logic                 claim_valid,
   input  logic [AW-1:0]        claim_addr,
   output logic [RF_NREGS-1:0]  busy,
   output logic                 claim_err
);

   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0] grant;
   logic [IW-1:0]   winner;
   logic            any_req;
   logic            transfer;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_data;

   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic            we_q, we_d;
   logic [AW-1:0]   wa_q, wa_d;
   logic [DW-1:0]   wd_q, wd_d;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_arbiter (
      .req_i    (req_valid),
      .ptr_i    (rr_ptr_q),
      .grant_o  (grant),
      .winner_o (winner),
      .any_o    (any_req)
   );

   // Grant is masked during reset so no requester believes it was accepted.
   assign req_ready = rst_n ? grant : '0;
   assign transfer  = rst_n & any_req;
   assign win_addr  = req_addr[int'(winner)*AW +: AW];
   assign win_data  = req_data[int'(winner)*DW +: DW];

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      we_d     = 1'b0;
      wa_d     = wa_q;
      wd_d     = wd_q;
      if (transfer) begin
         rr_ptr_d = IW'(wrap_inc(int'(winner), NREQ));
         we_d     = (win_addr != REG_ZERO);
         wa_d     = win_addr;
         wd_d     = win_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         we_q     <= 1'b0;
         wa_q     <= '0;
         wd_q     <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         we_q     <= we_d;
         wa_q     <= wa_d;
         wd_q     <= wd_d;
      end
   end

   assign we = we_q;
   assign wa = wa_q;
   assign wd = wd_q;

`ifdef RF_WB_SCOREBOARD_EN
   logic [RF_NREGS-1:0] busy_q, busy_d;
   logic                claim_err_q, claim_err_d;

   // The claim is applied after the commit clear so a same-address set wins.
   always_comb begin
      busy_d      = busy_q;
      claim_err_d = 1'b0;
      if (we_q) begin
         busy_d[wa_q] = 1'b0;
      end
      if (claim_valid && (claim_addr != REG_ZERO)) begin
         if (busy_q[claim_addr]) begin
            claim_err_d = 1'b1;
         end else begin
            busy_d[claim_addr] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q      <= '0;
         claim_err_q <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         claim_err_q <= claim_err_d;
      end
   end

   assign busy      = busy_q;
   assign claim_err = claim_err_q;
`else
   logic unused_claim;
   assign unused_claim = ^{claim_valid, claim_addr};
   assign busy         = '0;
   assign claim_err    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*DW-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic                we;
   logic [AW-1:0]       wa;
   logic [DW-1:0]       wd;
   logic                claim_valid;
   logic [AW-1:0]       claim_addr;
   logic [31:0]         busy;
   logic                claim_err;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .we          (we),
      .wa          (wa),
      .wd          (wd),
      .claim_valid (claim_valid),
      .claim_addr  (claim_addr),
      .busy        (busy),
      .claim_err   (claim_err)
   );

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   int          m_ptr;
   logic        m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   logic [31:0] m_busy;
   logic        m_err;
   logic [2:0]  obs_rdy;
   logic [2:0]  xfer;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
      req_valid[i]          = v;
      req_addr[i*AW +: AW]  = a;
      req_data[i*DW +: DW]  = d;
   endtask

   // One clock: check the grant against the rotating-priority rule, advance the model, check outputs.
   task automatic cycle();
      int          g;
      logic [2:0]  exp_rdy;
      logic [31:0] nb;
      logic        ne;
      #1;
      g = -1;
      if (rst_n === 1'b1) begin
         for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
         end
      end
      exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
      obs_rdy = req_ready;
      check("req_ready", {61'd0, req_ready}, {61'd0, exp_rdy});
      xfer = exp_rdy & req_valid;
      if (rst_n !== 1'b1) begin
         m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_busy = 0; m_err = 0;
      end else begin
         nb = m_busy;
         ne = 1'b0;
`ifdef RF_WB_SCOREBOARD_EN
         if (m_we) nb[m_wa] = 1'b0;
         if (claim_valid && claim_addr != 0) begin
            if (m_busy[claim_addr]) ne = 1'b1;
            else nb[claim_addr] = 1'b1;
         end
`endif
         m_busy = nb;
         m_err  = ne;
         if (g >= 0) begin
            m_wa  = req_addr[g*AW +: AW];
            m_wd  = req_data[g*DW +: DW];
            m_we  = (m_wa != 0);
            m_ptr = (g + 1) % NREQ;
         end else begin
            m_we = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check("we", {63'd0, we}, {63'd0, m_we});
      check("wa", {59'd0, wa}, {59'd0, m_wa});
      check("wd", {32'd0, wd}, {32'd0, m_wd});
      check("busy", {32'd0, busy}, {32'd0, m_busy});
      check("claim_err", {63'd0, claim_err}, {63'd0, m_err});
   endtask

   initial begin
      m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_busy = 0; m_err = 0;
      xfer = 0; obs_rdy = 0;
      rst_n = 1'b0;
      claim_valid = 1'b0;
      claim_addr  = '0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + i);
      @(posedge clk);
      #1;

      // Reset held two cycles with every requester valid.
      cycle();
      check("reset_ready", {61'd0, obs_rdy}, 64'd0);
      cycle();
      check("reset_we", {63'd0, we}, 64'd0);

      // Contention: grants rotate 0,1,2,0,1,2 starting at index 0.
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         check("contend_order", {61'd0, obs_rdy}, 64'(1 << (k % 3)));
      end

      // Single write from requester 1.
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 32'd0);
      set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
      cycle();
      check("single_ready", {61'd0, obs_rdy}, 64'b010);
      check("single_we", {63'd0, we}, 64'd1);
      check("single_wa", {59'd0, wa}, 64'd5);
      check("single_wd", {32'd0, wd}, 64'hDEADBEEF);
      set_req(1, 1'b0, 5'd0, 32'd0);
      cycle();
      check("single_we_off", {63'd0, we}, 64'd0);

      // x0 write is accepted but never enables the write port.
      set_req(0, 1'b1, 5'd0, 32'h1234);
      set_req(1, 1'b1, 5'd6, 32'h66);
      cycle();
      check("x0_ready", {61'd0, obs_rdy}, 64'b001);
      check("x0_we", {63'd0, we}, 64'd0);
      set_req(0, 1'b0, 5'd0, 32'd0);
      cycle();
      check("after_x0_ready", {61'd0, obs_rdy}, 64'b010);
      set_req(1, 1'b0, 5'd0, 32'd0);

      // Scoreboard claims, duplicate claim, commit clear and same-cycle set/clear.
      claim_valid = 1'b1; claim_addr = 5'd7;
      cycle();
      cycle();
`ifdef RF_WB_SCOREBOARD_EN
      check("dup_claim_err", {63'd0, claim_err}, 64'd1);
      check("busy7_set", {63'd0, busy[7]}, 64'd1);
`endif
      claim_valid = 1'b0;
      cycle();
      check("claim_err_pulse", {63'd0, claim_err}, 64'd0);
      set_req(2, 1'b1, 5'd7, 32'h77);
      cycle();
      set_req(2, 1'b0, 5'd0, 32'd0);
      cycle();
`ifdef RF_WB_SCOREBOARD_EN
      check("busy7_clear", {63'd0, busy[7]}, 64'd0);
`endif
      set_req(0, 1'b1, 5'd9, 32'h99);
      cycle();
      set_req(0, 1'b0, 5'd0, 32'd0);
      claim_valid = 1'b1; claim_addr = 5'd9;
      cycle();
      claim_valid = 1'b0;
      cycle();
`ifdef RF_WB_SCOREBOARD_EN
      check("busy9_set_wins", {63'd0, busy[9]}, 64'd1);
`endif

      // Reset in the cycle after acceptance drops the pending write and rewinds the pointer.
      set_req(0, 1'b1, 5'd4, 32'h44);
      cycle();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 10), 32'h200 + i);
      rst_n = 1'b0;
      cycle();
      check("rst_mid_we", {63'd0, we}, 64'd0);
      check("rst_mid_busy", {32'd0, busy}, 64'd0);
      rst_n = 1'b1;
      cycle();
      check("rst_mid_ptr", {61'd0, obs_rdy}, 64'b001);

      // Randomized protocol-conforming traffic against the model.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || xfer[i]) begin
               if ($urandom_range(0, 3) != 0)
                  set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
               else
                  set_req(i, 1'b0, 5'd0, 32'd0);
            end
         end
         claim_valid = 1'($urandom_range(0, 1));
         claim_addr  = 5'($urandom_range(0, 31));
         cycle();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
